// File: rtl/mini_cpu_core.sv
// Register-file mini CPU: one instruction per instr handshake, result offered on a display handshake.
// Build option MINI_CPU_SAT_ARITH_EN: ADD/ADDI/SUB/SUBI/MUL saturate on signed overflow instead of wrapping.
module mini_cpu_core #(
    parameter int DATA_W     = 16,
    parameter int REG_ADDR_W = 4,
    parameter int IMM_W      = 6
) (
    input  logic                          clk_i,
    input  logic                          reset_i,
    input  logic                          instr_valid_i,
    output logic                          instr_ready_o,
    input  logic [2*REG_ADDR_W+IMM_W+3:0] instr_i,
    output logic                          disp_valid_o,
    input  logic                          disp_ready_i,
    output logic [2:0]                    disp_opcode_o,
    output logic [REG_ADDR_W-1:0]         disp_reg_o,
    output logic [DATA_W-1:0]             disp_value_o,
    output logic                          ovf_o
);
    localparam int INSTR_W = 2*REG_ADDR_W + IMM_W + 4;
    localparam int PW      = DATA_W + IMM_W + 1;
    localparam int CW      = $clog2(IMM_W + 1);
    localparam int NREG    = 2**REG_ADDR_W;

    typedef enum logic [2:0] {S_IDLE, S_EXEC, S_MUL, S_WRITE, S_DISP} state_t;

    state_t                state_q, state_d;
    logic [INSTR_W-1:0]    instr_q, instr_d;
    logic [DATA_W-1:0]     rf_q [NREG];
    logic [DATA_W-1:0]     src1_val_q, src1_val_d, res_q, res_d;
    logic                  res_ovf_q, res_ovf_d;
    logic [PW-1:0]         acc_q, acc_d, mcand_q, mcand_d, acc_step, prod;
    logic [IMM_W-1:0]      mbits_q, mbits_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic                  disp_valid_q, disp_valid_d, ovf_q, ovf_d;
    logic [2:0]            disp_op_q, disp_op_d;
    logic [REG_ADDR_W-1:0] disp_reg_q, disp_reg_d;
    logic [DATA_W-1:0]     disp_val_q, disp_val_d;
    logic                  rf_we, rf_clr;

    logic [2:0]            opcode;
    logic [REG_ADDR_W-1:0] dest, src1, src2;
    logic [IMM_W:0]        low;
    logic                  imm_sign;
    logic [DATA_W-1:0]     mag_ext, imm, src1_val, src2_val;

    assign opcode   = instr_q[INSTR_W-1 -: 3];
    assign dest     = instr_q[IMM_W+1+REG_ADDR_W +: REG_ADDR_W];
    assign src1     = instr_q[IMM_W+1 +: REG_ADDR_W];
    assign low      = instr_q[IMM_W:0];
    assign src2     = low[IMM_W -: REG_ADDR_W];
    assign imm_sign = low[IMM_W];
    assign mag_ext  = DATA_W'(low[IMM_W-1:0]);
    assign imm      = imm_sign ? -mag_ext : mag_ext;
    assign src1_val = rf_q[src1];
    assign src2_val = rf_q[src2];

    function automatic logic [PW-1:0] sx(input logic [DATA_W-1:0] v);
        return {{(PW-DATA_W){v[DATA_W-1]}}, v};
    endfunction

    // Narrow a wide signed result to DATA_W; the top bit of the return is the overflow flag.
    function automatic logic [DATA_W:0] fit(input logic [PW-1:0] v);
        logic             in_range;
        logic [DATA_W-1:0] r;
        in_range = (v[PW-1:DATA_W-1] == '0) || (v[PW-1:DATA_W-1] == '1);
        r        = v[DATA_W-1:0];
`ifdef MINI_CPU_SAT_ARITH_EN
        if (!in_range)
            r = v[PW-1] ? {1'b1, {(DATA_W-1){1'b0}}} : {1'b0, {(DATA_W-1){1'b1}}};
`endif
        return {!in_range, r};
    endfunction

    always_comb begin
        state_d      = state_q;
        instr_d      = instr_q;
        src1_val_d   = src1_val_q;
        res_d        = res_q;
        res_ovf_d    = res_ovf_q;
        acc_d        = acc_q;
        mcand_d      = mcand_q;
        mbits_d      = mbits_q;
        cnt_d        = cnt_q;
        disp_valid_d = disp_valid_q;
        disp_op_d    = disp_op_q;
        disp_reg_d   = disp_reg_q;
        disp_val_d   = disp_val_q;
        ovf_d        = ovf_q;
        rf_we        = 1'b0;
        rf_clr       = 1'b0;
        acc_step     = acc_q + (mbits_q[0] ? mcand_q : '0);
        prod         = imm_sign ? -acc_step : acc_step;
        case (state_q)
            S_IDLE: if (instr_valid_i) begin
                instr_d = instr_i;
                state_d = S_EXEC;
            end
            S_EXEC: begin
                src1_val_d = src1_val;
                res_d      = '0;
                res_ovf_d  = 1'b0;
                state_d    = S_WRITE;
                case (opcode)
                    3'd0: res_d = imm;
                    3'd1: {res_ovf_d, res_d} = fit(sx(src1_val) + sx(src2_val));
                    3'd2: {res_ovf_d, res_d} = fit(sx(src1_val) + sx(imm));
                    3'd3: {res_ovf_d, res_d} = fit(sx(src1_val) - sx(src2_val));
                    3'd4: {res_ovf_d, res_d} = fit(sx(src1_val) - sx(imm));
                    3'd5: begin
                        acc_d   = '0;
                        mcand_d = sx(src1_val);
                        mbits_d = low[IMM_W-1:0];
                        cnt_d   = '0;
                        state_d = S_MUL;
                    end
                    default: ;
                endcase
            end
            // One magnitude bit per cycle, LSB first; sign applied on the final step.
            S_MUL: begin
                acc_d   = acc_step;
                mcand_d = mcand_q << 1;
                mbits_d = mbits_q >> 1;
                cnt_d   = cnt_q + CW'(1);
                if (cnt_q == CW'(IMM_W-1)) begin
                    {res_ovf_d, res_d} = fit(prod);
                    state_d            = S_WRITE;
                end
            end
            S_WRITE: begin
                rf_we        = (opcode <= 3'd5);
                rf_clr       = (opcode == 3'd6);
                disp_reg_d   = (opcode == 3'd7) ? src1 : dest;
                disp_val_d   = (opcode == 3'd7) ? src1_val_q : res_q;
                disp_op_d    = opcode;
                ovf_d        = res_ovf_q;
                disp_valid_d = 1'b1;
                state_d      = S_DISP;
            end
            S_DISP: if (disp_ready_i) begin
                disp_valid_d = 1'b0;
                state_d      = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q      <= S_IDLE;
            instr_q      <= '0;
            src1_val_q   <= '0;
            res_q        <= '0;
            res_ovf_q    <= 1'b0;
            acc_q        <= '0;
            mcand_q      <= '0;
            mbits_q      <= '0;
            cnt_q        <= '0;
            disp_valid_q <= 1'b0;
            disp_op_q    <= '0;
            disp_reg_q   <= '0;
            disp_val_q   <= '0;
            ovf_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            instr_q      <= instr_d;
            src1_val_q   <= src1_val_d;
            res_q        <= res_d;
            res_ovf_q    <= res_ovf_d;
            acc_q        <= acc_d;
            mcand_q      <= mcand_d;
            mbits_q      <= mbits_d;
            cnt_q        <= cnt_d;
            disp_valid_q <= disp_valid_d;
            disp_op_q    <= disp_op_d;
            disp_reg_q   <= disp_reg_d;
            disp_val_q   <= disp_val_d;
            ovf_q        <= ovf_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i || rf_clr) begin
            for (int i = 0; i < NREG; i++) rf_q[i] <= '0;
        end else if (rf_we) begin
            rf_q[dest] <= res_q;
        end
    end

    assign instr_ready_o = (state_q == S_IDLE);
    assign disp_valid_o  = disp_valid_q;
    assign disp_opcode_o = disp_op_q;
    assign disp_reg_o    = disp_reg_q;
    assign disp_value_o  = disp_val_q;
    assign ovf_o         = ovf_q;
endmodule

// File: doc/mini_cpu_core.md
Name: mini_cpu_core

Overview:
- Parametrised successor of the switch-driven mini CPU.
- Owns a register file (2**REG_ADDR_W entries of DATA_W bits) and executes one 8-opcode instruction per valid/ready handshake.
- Replaces button edge detection with instr_valid/instr_ready, and LCD start pulsing with a disp_valid/disp_ready handshake.
- Adds a multi-cycle shift-add multiplier and a signed-overflow flag. Sits between the switch/debounce front end and lcd_controller.

Parameters:
- DATA_W, 16: register and result width.
- REG_ADDR_W, 4: register index width; register count = 2**REG_ADDR_W.
- IMM_W, 6: immediate magnitude width. Constraint: REG_ADDR_W <= IMM_W+1.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous active-high reset.
- instr_valid  in  1  instruction offered.
- instr_ready  out  1  core can accept; high only in IDLE.
- instr  in  3+2*REG_ADDR_W+IMM_W+1  {opcode[2:0], dest, src1, low[IMM_W:0]}.
- disp_valid  out  1  display record available.
- disp_ready  in  1  display sink accepts record.
- disp_opcode  out  3  opcode of the completed instruction.
- disp_reg  out  REG_ADDR_W  register shown.
- disp_value  out  DATA_W  value shown.
- ovf  out  1  signed overflow of the last completed instruction.

Behaviour:
- Decode:
  - src2 = low[IMM_W -: REG_ADDR_W].
  - Immediate is sign-magnitude: sign = low[IMM_W], mag = low[IMM_W-1:0]. It is converted to two's complement and sign-extended to DATA_W. -0 equals 0.
- Opcodes:
  - 0 LOAD: dest=imm.
  - 1 ADD: dest=src1+src2.
  - 2 ADDI: dest=src1+imm.
  - 3 SUB: dest=src1-src2.
  - 4 SUBI: dest=src1-imm.
  - 5 MUL: dest=src1*imm.
  - 6 CLEAR: all registers set to 0.
  - 7 DISPLAY: no write.
- Arithmetic: modulo 2**DATA_W. ovf=1 when the true signed result lies outside the DATA_W signed range. ovf=0 for LOAD, CLEAR and DISPLAY.
- States: IDLE, EXEC, MUL, WRITE, DISP.
  - IDLE: instr_ready=1. When instr_valid=1, latch instr and go to EXEC.
  - EXEC: register src1/src2 operands. Opcode 5 goes to MUL; all others compute the result and go to WRITE.
  - MUL: shift-add over the IMM_W magnitude bits, one bit per cycle, for exactly IMM_W cycles. Negate the product if sign=1. Go to WRITE.
  - WRITE: commit to the register file (or clear all for CLEAR).
    - Load disp_reg: src1 for DISPLAY, dest otherwise.
    - Load disp_value: imm for LOAD, the src1 value for DISPLAY, 0 for CLEAR, the result otherwise.
    - Load disp_opcode and ovf, assert disp_valid, go to DISP.
  - DISP: hold disp_valid and all disp_* outputs stable until disp_ready=1. In the handshake cycle, drop disp_valid and go to IDLE.
- Latency from the accept edge:
  - Non-MUL instructions: disp_valid rises 3 cycles later.
  - MUL: disp_valid rises 3+IMM_W cycles later.
  - instr_ready returns 1 the cycle after the disp handshake.
- Reads use register contents from before the current instruction's write, so dest==src is legal.
- instr_valid outside IDLE is ignored and no instruction is dropped, because instr_ready=0.
- instr and disp_ready may change freely while the core is not sampling them.
- Reset, at any time including mid-MUL or DISP:
  - Next edge: state=IDLE, all registers=0, disp_valid=0, disp_reg=0, disp_value=0, disp_opcode=0, ovf=0.
  - The in-flight instruction is discarded with no register write.
- disp_ready asserted while disp_valid=0 has no effect.

Optional Feature:
- Macro: MINI_CPU_SAT_ARITH_EN.
- Defined: ADD, ADDI, SUB, SUBI and MUL saturate to +(2**(DATA_W-1)-1) or -(2**(DATA_W-1)) on overflow. ovf is still set. The saturated value is the one written and displayed.
- Undefined: wrap-around modulo 2**DATA_W.

Test Plan:
- LOAD r1, imm +5 (instr=18'b000_0001_0000_0000101):
  - Disp record {op 0, reg 1, value 5, ovf 0} appears 3 cycles after accept.
- ADDI r2=r1+(-3) (low=7'b1000011):
  - disp_value=2.
  - A following ADD r3=r1+r2 gives 7.
- LOAD r4=63; MUL r5=r4*63, then MUL r6=r5*63:
  - r5=3969, with disp_valid 9 cycles after accept.
  - r6=0xD0BF with ovf=1.
  - Under MINI_CPU_SAT_ARITH_EN, r6=0x7FFF with ovf=1.
- Hold disp_ready=0 for 10 cycles after any instruction:
  - disp_valid and disp_* stay constant and instr_ready stays 0.
  - A pulsed instr_valid is not accepted.
  - Release gives the handshake, then instr_ready=1 on the next cycle.
- CLEAR, then DISPLAY r1:
  - Record {op 6, reg dest, value 0}, then {op 7, reg 1, value 0}.
- Assert reset 2 cycles into a MUL targeting r5:
  - disp_valid never rises and r5 reads 0 afterwards.
  - instr_ready=1 one cycle after reset is released.
